// File: rtl/factor_scheduler.sv
// factor_scheduler: walks Mersenne factor candidates d=2kp+1 and dispatches them to a divisibility engine.
// Optional MOD8_FILTER_EN skips candidates with d mod 8 not in {1,7} before engine use.
module factor_scheduler #(
    parameter int W = 32
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_p,
    input  logic [W-1:0] cmd_kmax,
    input  logic         abort,
    output logic         eng_start,
    output logic [W-1:0] eng_p,
    output logic [W-1:0] eng_d,
    input  logic         eng_dividesBy,
    input  logic         eng_finished,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         ovf,
    output logic [W-1:0] factor,
    output logic [W-1:0] k_out,
    output logic [W-1:0] issued
);
    typedef enum logic [2:0] {IDLE, GEN, FILT, ISSUE, WAIT, DRAIN, DONE} state_t;

    state_t       r_state, w_next;
    logic [W-1:0] r_p, r_kmax, r_k, r_factor, r_kout, r_issued;
    logic [W:0]   r_d;
    logic         r_found, r_ovf;
    logic         w_accept, w_last, w_take, w_trivial, w_hit, w_miss, w_adv;

`ifdef MOD8_FILTER_EN
    assign w_accept = (r_d[2:0] == 3'b001) || (r_d[2:0] == 3'b111);
`else
    assign w_accept = 1'b1;
`endif

    assign w_last    = (r_k == r_kmax);
    assign w_take    = (r_state == IDLE) && cmd_valid;
    assign w_trivial = (cmd_p < W'(2)) || (cmd_kmax == '0);
    assign w_hit     = (r_state == WAIT) && eng_finished && !abort && eng_dividesBy;
    assign w_miss    = (r_state == WAIT) && eng_finished && !abort && !eng_dividesBy;
    assign w_adv     = !w_last && (w_miss || ((r_state == FILT) && !abort && !w_accept));

    always_comb begin
        w_next    = r_state;
        eng_start = 1'b0;
        case (r_state)
            IDLE:    w_next = cmd_valid ? (w_trivial ? DONE : GEN) : IDLE;
            GEN:     w_next = abort ? IDLE : (r_d[W] ? DONE : FILT);
            FILT:    w_next = abort ? IDLE : (w_accept ? ISSUE : (w_last ? DONE : GEN));
            ISSUE: begin
                w_next    = abort ? IDLE : WAIT;
                eng_start = !abort;
            end
            WAIT:    w_next = eng_finished ? (abort ? IDLE : ((eng_dividesBy || w_last) ? DONE : GEN))
                                           : (abort ? DRAIN : WAIT);
            DRAIN:   w_next = eng_finished ? IDLE : DRAIN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= IDLE;
            r_p      <= '0;
            r_kmax   <= '0;
            r_k      <= '0;
            r_d      <= '0;
            r_found  <= 1'b0;
            r_ovf    <= 1'b0;
            r_factor <= '0;
            r_kout   <= '0;
            r_issued <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_p      <= cmd_p;
                r_kmax   <= cmd_kmax;
                r_k      <= W'(1);
                r_d      <= {cmd_p, 1'b1};
                r_found  <= 1'b0;
                r_ovf    <= 1'b0;
                r_factor <= '0;
                r_issued <= '0;
            end
            if ((r_state == GEN) && !abort && r_d[W])
                r_ovf <= 1'b1;
            if (eng_start)
                r_issued <= r_issued + W'(1);
            if (w_hit) begin
                r_found  <= 1'b1;
                r_factor <= r_d[W-1:0];
                r_kout   <= r_k;
            end
            // d stays W+1 bits: overflow is caught in GEN before another step can wrap it
            if (w_adv) begin
                r_k <= r_k + W'(1);
                r_d <= r_d + {r_p, 1'b0};
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign eng_p     = r_p;
    assign eng_d     = r_d[W-1:0];
    assign found     = r_found;
    assign ovf       = r_ovf;
    assign factor    = r_factor;
    assign k_out     = r_kout;
    assign issued    = r_issued;
endmodule

// File: tb/tb_factor_scheduler.sv
// tb_factor_scheduler: directed checks of factor_scheduler against a 5-cycle behavioural engine.
module tb_factor_scheduler;
    logic        sys_clk = 1'b0, sys_rst = 1'b1;
    logic        cmd_valid = 1'b0, abort = 1'b0;
    logic [31:0] cmd_p = '0, cmd_kmax = '0;
    logic        cmd_ready, eng_start, busy, done, found, ovf;
    logic [31:0] eng_p, eng_d, factor, k_out, issued;
    logic        eng_dividesBy = 1'b0, eng_finished = 1'b0;

    int n_cmp = 0, n_bad = 0, n_start = 0, n_done = 0;
    logic [31:0] last_d = '0;

`ifdef MOD8_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    factor_scheduler #(.W(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_p(cmd_p), .cmd_kmax(cmd_kmax),
        .abort(abort), .eng_start(eng_start), .eng_p(eng_p), .eng_d(eng_d),
        .eng_dividesBy(eng_dividesBy), .eng_finished(eng_finished),
        .busy(busy), .done(done), .found(found), .ovf(ovf),
        .factor(factor), .k_out(k_out), .issued(issued)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic bit divides(input logic [31:0] p, input logic [31:0] d);
        longint unsigned r = 1, b, m = 64'(d);
        if (d < 2) return 1'b0;
        b = 2 % m;
        for (int i = 0; i < 32; i++) begin
            if (p[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r == 1;
    endfunction

    // engine model: answers 2^p-1 mod d == 0, finishing 5 cycles after the start edge
    int eng_cnt = 0;
    bit eng_res = 1'b0;
    always @(posedge sys_clk) begin
        logic st;
        logic [31:0] pp, dd;
        st = eng_start; pp = eng_p; dd = eng_d;
        if (eng_start) begin n_start++; last_d = eng_d; end
        if (done) n_done++;
        #1;
        eng_finished = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin eng_finished = 1'b1; eng_dividesBy = eng_res; end
        end
        if (st) begin eng_cnt = 5; eng_res = divides(pp, dd); end
    end

    task automatic step();
        @(posedge sys_clk); #1;
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] k);
        step();
        cmd_p = p; cmd_kmax = k; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (eng_start) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({busy, done, found, ovf, eng_start, cmd_ready} !== 6'b000001) begin
            n_bad++; $display("FAIL reset_flags got=%b want=000001", {busy, done, found, ovf, eng_start, cmd_ready});
        end
        n_cmp++;
        if ({eng_p, eng_d, factor, k_out, issued} !== 160'd0) begin
            n_bad++; $display("FAIL reset_data got p=%0h d=%0h f=%0h k=%0h i=%0h want all 0", eng_p, eng_d, factor, k_out, issued);
        end
        step(); sys_rst = 1'b0; step();
    endtask

    task automatic test_found_p11();
        bit ok; int s0 = n_start, d0 = n_done;
        send(11, 10);
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL p11_timeout got=no done want=done"); end
        n_cmp++;
        if ({found, ovf, factor, k_out, issued} !== {1'b1, 1'b0, 32'd23, 32'd1, 32'd1}) begin
            n_bad++; $display("FAIL p11_result got f=%b o=%b fac=%0d k=%0d i=%0d want 1 0 23 1 1", found, ovf, factor, k_out, issued);
        end
        n_cmp++;
        if (n_start - s0 != 1 || last_d !== 32'd23) begin
            n_bad++; $display("FAIL p11_starts got=%0d d=%0d want=1 d=23", n_start - s0, last_d);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || n_done - d0 != 1) begin
            n_bad++; $display("FAIL p11_pulse got done=%b rdy=%b pulses=%0d want 0 1 1", done, cmd_ready, n_done - d0);
        end
    endtask

    task automatic test_p29();
        bit ok; int s0 = n_start;
        logic [31:0] exp_i;
        exp_i = FILT_ON ? 32'd2 : 32'd4;
        send(29, 10);
        wait_done(ok);
        n_cmp++;
        if (!ok || {found, factor, k_out, issued} !== {1'b1, 32'd233, 32'd4, exp_i}) begin
            n_bad++; $display("FAIL p29_result got ok=%b f=%b fac=%0d k=%0d i=%0d want 1 1 233 4 %0d", ok, found, factor, k_out, issued, exp_i);
        end
        n_cmp++;
        if (n_start - s0 != int'(exp_i)) begin
            n_bad++; $display("FAIL p29_starts got=%0d want=%0d", n_start - s0, exp_i);
        end
        step();
    endtask

    task automatic test_p13_exhaust();
        bit ok; int s0 = n_start;
        logic [31:0] exp_i;
        exp_i = FILT_ON ? 32'd1 : 32'd3;
        send(13, 3);
        wait_done(ok);
        n_cmp++;
        if (!ok || {found, ovf, issued} !== {1'b0, 1'b0, exp_i} || n_start - s0 != int'(exp_i) || last_d !== 32'd79) begin
            n_bad++; $display("FAIL p13_result got ok=%b f=%b o=%b i=%0d starts=%0d d=%0d want 1 0 0 %0d %0d 79", ok, found, ovf, issued, n_start - s0, last_d, exp_i, exp_i);
        end
        step();
    endtask

    task automatic test_ovf();
        bit ok; int s0 = n_start;
        send(32'h7FFF_FFFF, 5);
        wait_done(ok);
        n_cmp++;
        if (!ok || {found, ovf, issued} !== {1'b0, 1'b1, 32'd1} || n_start - s0 != 1 || last_d !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL ovf_result got ok=%b f=%b o=%b i=%0d starts=%0d d=%h want 1 0 1 1 1 ffffffff", ok, found, ovf, issued, n_start - s0, last_d);
        end
        step();
    endtask

    task automatic test_trivial();
        logic [31:0] pv [2] = '{32'd5, 32'd1};
        logic [31:0] kv [2] = '{32'd0, 32'd7};
        for (int i = 0; i < 2; i++) begin
            int s0 = n_start;
            send(pv[i], kv[i]);
            n_cmp++;
            if ({done, busy, found, ovf, issued} !== {4'b1100, 32'd0} || n_start != s0) begin
                n_bad++; $display("FAIL trivial%0d got done=%b busy=%b f=%b o=%b i=%0d starts=%0d want 1 1 0 0 0 0", i, done, busy, found, ovf, issued, n_start - s0);
            end
            step();
            n_cmp++;
            if (done !== 1'b0 || cmd_ready !== 1'b1) begin
                n_bad++; $display("FAIL trivial%0d_end got done=%b rdy=%b want 0 1", i, done, cmd_ready);
            end
        end
    endtask

    task automatic test_abort_gen();
        int s0 = n_start, d0 = n_done;
        send(11, 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL abort_gen got busy=%b rdy=%b want 0 1", busy, cmd_ready);
        end
        repeat (8) step();
        n_cmp++;
        if (n_start != s0 || n_done != d0) begin
            n_bad++; $display("FAIL abort_gen_quiet got starts=%0d dones=%0d want 0 0", n_start - s0, n_done - d0);
        end
    endtask

    task automatic test_abort_wait();
        bit ok; int d0 = n_done;
        send(11, 10);
        wait_issue(ok);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (!ok || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort_drain got ok=%b busy=%b rdy=%b want 1 1 0", ok, busy, cmd_ready);
        end
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_drain_hold got busy=%b want 1", busy);
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            step();
        end
        n_cmp++;
        if (!ok || cmd_ready !== 1'b1 || n_done != d0 || eng_cnt != 0) begin
            n_bad++; $display("FAIL abort_wait_end got idle=%b rdy=%b dones=%0d eng_busy=%0d want 1 1 0 0", ok, cmd_ready, n_done - d0, eng_cnt);
        end
    endtask

    task automatic test_reset_wait();
        bit ok; int s0, d0;
        send(11, 10);
        wait_issue(ok);
        step();
        #2 sys_rst = 1'b1;
        #1;
        n_cmp++;
        if (!ok || {busy, done, found, ovf, eng_start, cmd_ready} !== 6'b000001 || {eng_p, eng_d, issued, factor, k_out} !== 160'd0) begin
            n_bad++; $display("FAIL reset_wait got ok=%b flags=%b p=%0d d=%0d i=%0d want 1 000001 0 0 0", ok, {busy, done, found, ovf, eng_start, cmd_ready}, eng_p, eng_d, issued);
        end
        step();
        sys_rst = 1'b0;
        s0 = n_start; d0 = n_done;
        repeat (10) step();
        n_cmp++;
        if (busy !== 1'b0 || found !== 1'b0 || n_done != d0 || n_start != s0) begin
            n_bad++; $display("FAIL reset_ignore got busy=%b f=%b dones=%0d starts=%0d want 0 0 0 0", busy, found, n_done - d0, n_start - s0);
        end
    endtask

    initial begin
        test_reset();
        test_found_p11();
        test_p29();
        test_trivial();
        test_p13_exhaust();
        test_ovf();
        test_abort_gen();
        test_abort_wait();
        test_reset_wait();
        test_found_p11();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
